// File: rtl/dm_pkg.sv
// Shared types and constants for the data-memory responder.
// Used by dm_responder and dm_be_merge.
package dm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] BE_WORD    = 4'hF;
  localparam logic [3:0] BE_HALF_LO = 4'h3;
  localparam logic [3:0] BE_HALF_HI = 4'hC;

  localparam int CNT_W  = 4;
  localparam int WORD_W = 32;

endpackage

// File: rtl/dm_be_merge.sv
// Byte-lane merge: each enabled lane takes the store data, the others keep the old byte.
module dm_be_merge
  import dm_pkg::*;
(
  input  logic [WORD_W-1:0] old_word,
  input  logic [WORD_W-1:0] wdata,
  input  logic [3:0]        be,
  output logic [WORD_W-1:0] new_word
);

  always_comb begin
    new_word = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) new_word[8*i +: 8] = wdata[8*i +: 8];
    end
  end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder with programmable wait states and one response pulse.
// Optional alignment checking is enabled by defining DM_ALIGN_CHECK_EN.
module dm_responder
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [3:0]        req_be,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int IDX_W  = $clog2(DEPTH_WORDS);
  localparam int LAT_AW = IDX_W + 2;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic                lat_we;
  logic [3:0]          lat_be;
  logic [LAT_AW-1:0]   lat_addr;
  logic [WORD_W-1:0]   lat_wdata;
  logic [WORD_W-1:0]   mem [DEPTH_WORDS];

  logic                accept;
  logic                commit;
  logic                c_we;
  logic [3:0]          c_be;
  logic [LAT_AW-1:0]   c_addr;
  logic [WORD_W-1:0]   c_wdata;
  logic [IDX_W-1:0]    c_idx;
  logic [WORD_W-1:0]   old_word;
  logic [WORD_W-1:0]   merged_word;
  logic                c_err;
  logic                unused_bits;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_valid && req_ready;

  // With zero wait states the access commits on the accept edge itself, so the
  // live request fields are used; otherwise the latched copy is.
  always_comb begin
    c_we    = lat_we;
    c_be    = lat_be;
    c_addr  = lat_addr;
    c_wdata = lat_wdata;
    if (state == IDLE) begin
      c_we    = req_we;
      c_be    = req_be;
      c_addr  = req_addr[LAT_AW-1:0];
      c_wdata = req_wdata;
    end
  end

  assign commit   = (WAIT_CYCLES == 0) ? accept
                                       : ((state == WAIT) && (cnt == CNT_W'(1)));
  assign c_idx    = c_addr[LAT_AW-1:2];
  assign old_word = mem[c_idx];

`ifdef DM_ALIGN_CHECK_EN
  assign c_err = ((c_addr[1:0] != 2'b00) && ((c_be == BE_WORD) || !c_we)) ||
                 (((c_be == BE_HALF_LO) || (c_be == BE_HALF_HI)) && c_addr[0]);
  assign unused_bits = ^req_addr[ADDR_W-1:LAT_AW];
`else
  assign c_err = 1'b0;
  assign unused_bits = ^{req_addr[ADDR_W-1:LAT_AW], c_addr[1:0]};
`endif

  dm_be_merge u_merge (
    .old_word (old_word),
    .wdata    (c_wdata),
    .be       (c_be),
    .new_word (merged_word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = (WAIT_CYCLES == 0) ? RESP : WAIT;
      WAIT:    if (cnt == CNT_W'(1)) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (accept) begin
      cnt       <= CNT_INIT;
      lat_we    <= req_we;
      lat_be    <= req_be;
      lat_addr  <= req_addr[LAT_AW-1:0];
      lat_wdata <= req_wdata;
    end else if (state == WAIT) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Commit edge: response registers load here and hold until the next commit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (commit) begin
      resp_rdata <= c_err ? '0 : (c_we ? merged_word : old_word);
      resp_err   <= c_err;
    end else if (accept) begin
      resp_err   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (commit && c_we && !c_err) begin
      mem[c_idx] <= merged_word;
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Randomised bench for dm_responder against a byte-lane memory model; also drives a
// zero-wait instance to exercise back-to-back accepts.
module tb_dm_responder;
  import dm_pkg::*;

  localparam int W      = 2;
  localparam int DEPTH  = 1024;
  localparam int ADDR_W = 32;
`ifdef DM_ALIGN_CHECK_EN
  localparam bit ALIGN_EN = 1'b1;
`else
  localparam bit ALIGN_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid, req_ready, req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;

  logic        z_valid, z_ready, z_we;
  logic [3:0]  z_be;
  logic [31:0] z_addr, z_wdata;
  logic        z_resp_valid, z_err;
  logic [31:0] z_rdata;

  dm_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(ADDR_W), .WAIT_CYCLES(W)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dm_responder #(.DEPTH_WORDS(16), .ADDR_W(32), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(z_valid), .req_ready(z_ready), .req_we(z_we), .req_be(z_be),
    .req_addr(z_addr), .req_wdata(z_wdata),
    .resp_valid(z_resp_valid), .resp_rdata(z_rdata), .resp_err(z_err)
  );

  always #5 clk = ~clk;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] mdl [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic model_err(input logic we, input logic [3:0] be, input logic [31:0] addr);
    logic mis_word, mis_half;
    mis_word = ((addr % 4) != 0) && ((be == 4'hF) || !we);
    mis_half = ((be == 4'h3) || (be == 4'hC)) && ((addr % 2) == 1);
    return ALIGN_EN && (mis_word || mis_half);
  endfunction

  // One full transaction on the WAIT_CYCLES instance, checked against the model.
  task automatic xact(input string tag, input logic we, input logic [3:0] be,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rd);
    int          k;
    int          idx;
    logic [31:0] exp_d;
    logic        e;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_be = be; req_addr = addr; req_wdata = wdata;
    k = 0;
    while (!req_ready && k < 40) begin @(negedge clk); k++; end
    check({tag, ".ready"}, req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    idx = int'((addr >> 2) % DEPTH);
    e   = model_err(we, be, addr);
    exp_d = mdl[idx];
    if (e) exp_d = 32'h0;
    else if (we) begin
      for (int b = 0; b < 4; b++) if (be[b]) exp_d[8*b +: 8] = wdata[8*b +: 8];
      mdl[idx] = exp_d;
    end
    k = 0;
    do begin
      @(negedge clk); k++;
      if (k == 1) check({tag, ".busy"}, req_ready, 0);
    end while (!resp_valid && k < 40);
    check({tag, ".lat"}, k, W + 1);
    check({tag, ".rdata"}, resp_rdata, exp_d);
    check({tag, ".err"}, resp_err, e);
    rd = resp_rdata;
    @(negedge clk);
    check({tag, ".pulse"}, resp_valid, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] zd;
    logic [31:0] a;
    req_valid = 0; req_we = 0; req_be = 0; req_addr = 0; req_wdata = 0;
    z_valid = 0; z_we = 0; z_be = 0; z_addr = 0; z_wdata = 0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.resp_valid", resp_valid, 0);
    check("rst.rdata", resp_rdata, 0);
    check("rst.err", resp_err, 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst.ready", req_ready, 1);

    xact("st_full", 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd);
    xact("ld_full", 1'b0, 4'h0, 32'h10, 32'h0, rd);
    check("ld_full.const", rd, 32'hDEADBEEF);
    xact("st_byte", 1'b1, 4'b0100, 32'h10, 32'h00AB0000, rd);
    check("st_byte.const", rd, 32'hDEABBEEF);
    xact("ld_byte", 1'b0, 4'hF, 32'h10, 32'h0, rd);
    check("ld_byte.const", rd, 32'hDEABBEEF);
    xact("st_be0", 1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, rd);
    check("st_be0.const", rd, 32'hDEABBEEF);
    xact("st_wrap", 1'b1, 4'hF, 32'h1000, 32'h11111111, rd);
    xact("ld_wrap", 1'b0, 4'hF, 32'h0, 32'h0, rd);
    check("ld_wrap.const", rd, 32'h11111111);

    // Abort a store to 0x20 while it is waiting.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_be = 4'hF; req_addr = 32'h20; req_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("abort.no_resp", resp_valid, 0);
    end
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    @(negedge clk);
    check("abort.ready", req_ready, 1);
    check("abort.rdata", resp_rdata, 0);
    xact("abort.ld20", 1'b0, 4'hF, 32'h20, 32'h0, rd);
    check("abort.ld20.const", rd, 32'h0);
    xact("abort.ld10", 1'b0, 4'hF, 32'h10, 32'h0, rd);
    check("abort.ld10.const", rd, 32'h0);

    xact("mis_st", 1'b1, 4'hF, 32'h22, 32'hCAFEF00D, rd);
    check("mis_st.const", rd, ALIGN_EN ? 32'h0 : 32'hCAFEF00D);
    xact("mis_ld", 1'b0, 4'hF, 32'h20, 32'h0, rd);
    check("mis_ld.const", rd, ALIGN_EN ? 32'h0 : 32'hCAFEF00D);

    for (int n = 0; n < 40; n++) begin
      a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      xact("rand", 1'($urandom), 4'($urandom), a, $urandom, rd);
    end

    // Zero-wait instance: store, then a held load request accepted every other cycle.
    zd = $urandom;
    @(negedge clk);
    z_valid = 1'b1; z_we = 1'b1; z_be = 4'hF; z_addr = 32'h4; z_wdata = zd;
    @(negedge clk);
    check("z.st.resp", z_resp_valid, 1);
    check("z.st.ready", z_ready, 0);
    check("z.st.rdata", z_rdata, zd);
    z_we = 1'b0; z_wdata = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      check("z.stream.ready", z_ready, (i % 2 == 1) ? 1 : 0);
      check("z.stream.resp", z_resp_valid, (i % 2 == 0) ? 1 : 0);
      if (i % 2 == 0) check("z.stream.rdata", z_rdata, zd);
    end
    z_valid = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Multi-cycle data-memory responder: the target end of the datapath's load/store interface (address, write data, read/write strobes).
- Replaces the zero-wait data memory so the core can be tested against realistic memory latency.
- Accepts one request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states, then commits the access to a word-organised array and returns exactly one response pulse.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the array; must be a power of two, ≥ 4.
- ADDR_W, 32: byte-address width of req_addr.
- WAIT_CYCLES, 2: extra wait states between accept and response; range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_be  input  4  byte enables for stores; bit i selects byte lane i (bits 8i+7:8i).
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  32  store data, already lane-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  word read; for stores, the merged word after the write.
- resp_err  output  1  access error, valid with resp_valid.

Behaviour:
- Interface rule: one clock; reset is asynchronous and active-low. The clock port is clk and the reset port is reset; reset is asserted at 0.
- Reset values:
  - state = IDLE.
  - req_ready = 1 after reset deasserts.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - Wait counter = 0.
  - All array words = 0.
- States:
  - IDLE: req_ready = 1, driven combinationally as (state == IDLE).
  - WAIT: request latched, counting wait states.
  - RESP: access committed, response presented.
- Accept:
  - A request is accepted on the rising edge where req_valid && req_ready.
  - On accept, latch addr, we, be and wdata, and load cnt = WAIT_CYCLES.
  - Next state is WAIT if WAIT_CYCLES > 0, otherwise RESP.
- Initiator rule: request fields are held stable while req_valid = 1 and req_ready = 0. The responder samples them only at accept.
- WAIT state:
  - cnt decrements by 1 each cycle.
  - On the edge where cnt == 1, commit the access and move to RESP.
- Commit:
  - Word index = latched addr[log2(DEPTH_WORDS)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
  - Store: each lane with be[i] = 1 takes wdata's lane; lanes with be[i] = 0 keep the old byte. be = 4'h0 leaves the word unchanged but still completes.
  - Load: be is ignored and the full word is returned.
- Response timing:
  - resp_rdata and resp_err are registered at commit.
  - resp_valid = 1 for exactly the one RESP cycle.
  - Latency from the accept edge to resp_valid high is WAIT_CYCLES + 1 cycles.
- After RESP the state returns to IDLE. The earliest next accept is the edge after the RESP cycle, so throughput is one request per WAIT_CYCLES + 2 cycles.
- There is no response backpressure: the initiator must consume the response in the RESP cycle.
- resp_rdata holds its value until the next commit. resp_err clears to 0 on the next accept.
- Reset mid-transaction: the transaction is aborted. An uncommitted store is not written, no response pulse is produced, and the array is zeroed.
- req_valid during WAIT or RESP is ignored; there is no queuing.

Optional Feature:
- Macro: DM_ALIGN_CHECK_EN.
- Defined:
  - resp_err = 1 with the response when either:
    - latched addr[1:0] != 2'b00 and be is 4'hF (or the access is a load), or
    - be is 4'b0011 or 4'b1100 and addr[0] = 1.
  - An erroring store is suppressed (array unchanged), and resp_rdata = 0 for any erroring access.
- Undefined: addr[1:0] is ignored entirely and resp_err is tied to 0.

Decomposition:
- Shared package dm_pkg:
  - State encoding: IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2.
  - BE constants: BE_WORD = 4'hF, BE_HALF_LO = 4'h3, BE_HALF_HI = 4'hC.
  - WAIT counter width constant (4).
- One natural sub-module, dm_be_merge: combinational lane merge of the old word, wdata and be into the new word. The FSM, counter and array stay in dm_responder.

Test Plan:
- WAIT_CYCLES = 2: store addr 0x10, be F, data 0xDEADBEEF → resp_valid high exactly 3 cycles after accept, for 1 cycle. A following load from 0x10 returns 0xDEADBEEF.
- Store be 4'b0100, data 0x00AB0000 to the 0xDEADBEEF word → load returns 0xDEABBEEF; store response rdata is 0xDEABBEEF.
- WAIT_CYCLES = 0 build: load accepted → resp_valid on the next cycle. req_valid held continuously → accepts every 2nd cycle; req_ready low during RESP.
- Wrap: DEPTH_WORDS = 1024, store 0x11111111 at 0x1000 → load at 0x0000 returns 0x11111111.
- Assert reset (0) during WAIT of a store to 0x20 → no resp_valid. After release: req_ready = 1 and a load from 0x20 returns 0.
- With DM_ALIGN_CHECK_EN: store be F to 0x22 → resp_err = 1, rdata 0, word 0x20 unchanged. Without the macro: same store writes word 0x20 and resp_err = 0.
